// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default widths for seq_match_counter
// Contents: state_t (IDLE/COUNT/REPORT), CNT_W_DEF, WIN_W_DEF
package seq_pkg;
   typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 16;
endpackage

// File: rtl/seq_match_counter_if.sv
// seq_match_counter_if: match-flag input, window control and result handshake
// Signals: z, start, win_len, out_ready (to counter); out_valid, out_count,
// out_ovf, busy (from counter). master = producer/consumer side, slave = counter.
interface seq_match_counter_if
   import seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
);
   logic             z;
   logic             start;
   logic [WIN_W-1:0] win_len;
   logic             out_ready;
   logic             out_valid;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             busy;
   modport master (
      output z, start, win_len, out_ready,
      input  out_valid, out_count, out_ovf, busy
   );
   modport slave (
      input  z, start, win_len, out_ready,
      output out_valid, out_count, out_ovf, busy
   );
endinterface

// File: rtl/seq_match_counter_rise_detect.sv
// rise_detect: registered previous-z with combinational rising-edge output
// Ports: clk, rst_n (async, active-low), z (input flag), rise (z & ~previous z)
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic z,
   output logic rise
);
   logic z_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) z_q <= 1'b0;
      else        z_q <= z;
   assign rise = z & ~z_q;
endmodule

// File: rtl/seq_match_counter.sv
// seq_match_counter: counts z rising edges over a programmable window and
// reports the saturating count through a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), bus (seq_match_counter_if.slave)
module seq_match_counter
   import seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_match_counter_if.slave   bus
);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, oc, oc_nxt;
   logic             ovf, ovf_nxt, ovf_inc, oo, oo_nxt;
   logic [WIN_W-1:0] rem, rem_nxt, win_eff;
   logic             rise, sat, load;
   rise_detect u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .z     (bus.z),
      .rise  (rise)
   );
   assign sat     = &cnt;
   assign cnt_inc = (rise && !sat) ? cnt + CNT_W'(1) : cnt;
   assign ovf_inc = ovf | (rise & sat);
   assign win_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
   // a new window may open from IDLE or on the very cycle a result is taken
   assign load    = bus.start && (state == IDLE || (state == REPORT && bus.out_ready));
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      rem_nxt   = rem;
      oc_nxt    = oc;
      oo_nxt    = oo;
      if (load) begin
         state_nxt = COUNT;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
         rem_nxt   = win_eff;
      end else if (state == COUNT) begin
         cnt_nxt = cnt_inc;
         ovf_nxt = ovf_inc;
         rem_nxt = rem - WIN_W'(1);
         // last window cycle: its own rise is folded into the reported result
         if (rem == WIN_W'(1)) begin
            state_nxt = REPORT;
            oc_nxt    = cnt_inc;
            oo_nxt    = ovf_inc;
         end
      end else if (state == REPORT && bus.out_ready) begin
         state_nxt = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ovf   <= 1'b0;
         rem   <= '0;
         oc    <= '0;
         oo    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
         rem   <= rem_nxt;
         oc    <= oc_nxt;
         oo    <= oo_nxt;
      end
   assign bus.out_valid = (state == REPORT);
   assign bus.busy      = (state != IDLE);
   assign bus.out_count = oc;
   assign bus.out_ovf   = oo;
endmodule

// File: tb/tb_seq_match_counter.sv
// tb_seq_match_counter: directed self-checking bench for seq_match_counter
// Drives an 8-bit-count instance and a 2-bit-count instance from one stimulus.
module tb_seq_match_counter;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   seq_match_counter_if #(.CNT_W(8), .WIN_W(16)) b8 ();
   seq_match_counter_if #(.CNT_W(2), .WIN_W(16)) b2 ();
   seq_match_counter #(.CNT_W(8), .WIN_W(16)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   seq_match_counter #(.CNT_W(2), .WIN_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   assign b2.z         = b8.z;
   assign b2.start     = b8.start;
   assign b2.win_len   = b8.win_len;
   assign b2.out_ready = b8.out_ready;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      b8.z = 1'b0;
      b8.start = 1'b0;
      b8.win_len = 16'd0;
      b8.out_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(b8.out_valid), 32'd0);
      chk("rst_busy",  32'(b8.busy),      32'd0);
      chk("rst_count", 32'(b8.out_count), 32'd0);
      chk("rst_ovf",   32'(b8.out_ovf),   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(b8.busy), 32'd0);
      // win 10, pulses at edges 2 and 7
      b8.start = 1'b1;
      b8.win_len = 16'd10;
      tick();
      chk("w10_busy", 32'(b8.busy), 32'd1);
      b8.start = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         b8.z = (e == 2 || e == 7);
         tick();
         chk("w10_novalid", 32'(b8.out_valid), 32'd0);
      end
      b8.z = 1'b0;
      b8.out_ready = 1'b1;
      tick();
      chk("w10_valid", 32'(b8.out_valid), 32'd1);
      chk("w10_count", 32'(b8.out_count), 32'd2);
      chk("w10_ovf",   32'(b8.out_ovf),   32'd0);
      tick();
      chk("w10_idle_valid", 32'(b8.out_valid), 32'd0);
      chk("w10_idle_busy",  32'(b8.busy),      32'd0);
      chk("w10_hold_count", 32'(b8.out_count), 32'd2);
      // win 4, pulse on last window cycle
      b8.start = 1'b1;
      b8.win_len = 16'd4;
      tick();
      b8.start = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         b8.z = (e == 4);
         tick();
      end
      chk("w4_last_valid", 32'(b8.out_valid), 32'd1);
      chk("w4_last_count", 32'(b8.out_count), 32'd1);
      b8.z = 1'b0;
      tick();
      chk("w4_last_idle", 32'(b8.busy), 32'd0);
      // win 4, pulse one cycle after the window
      b8.out_ready = 1'b0;
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      for (int e = 1; e <= 4; e++) tick();
      chk("w4_late_valid", 32'(b8.out_valid), 32'd1);
      chk("w4_late_count", 32'(b8.out_count), 32'd0);
      b8.z = 1'b1;
      tick();
      chk("w4_late_count2", 32'(b8.out_count), 32'd0);
      b8.z = 1'b0;
      b8.out_ready = 1'b1;
      tick();
      chk("w4_late_idle",  32'(b8.busy),      32'd0);
      chk("w4_late_hold",  32'(b8.out_count), 32'd0);
      // win 0 behaves as a one-cycle window
      b8.out_ready = 1'b0;
      b8.start = 1'b1;
      b8.win_len = 16'd0;
      tick();
      b8.start = 1'b0;
      b8.z = 1'b1;
      tick();
      chk("w0_valid", 32'(b8.out_valid), 32'd1);
      chk("w0_count", 32'(b8.out_count), 32'd1);
      b8.z = 1'b0;
      b8.out_ready = 1'b1;
      tick();
      chk("w0_idle", 32'(b8.busy), 32'd0);
      // REPORT stall: outputs stable, z toggles and start ignored
      b8.out_ready = 1'b0;
      b8.start = 1'b1;
      b8.win_len = 16'd3;
      tick();
      b8.start = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         b8.z = (e == 2);
         tick();
      end
      chk("stall_valid0", 32'(b8.out_valid), 32'd1);
      chk("stall_count0", 32'(b8.out_count), 32'd1);
      b8.start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b8.z = ~b8.z;
         tick();
         chk("stall_valid", 32'(b8.out_valid), 32'd1);
         chk("stall_count", 32'(b8.out_count), 32'd1);
         chk("stall_ovf",   32'(b8.out_ovf),   32'd0);
      end
      b8.start = 1'b0;
      b8.z = 1'b0;
      b8.out_ready = 1'b1;
      tick();
      chk("stall_idle", 32'(b8.busy), 32'd0);
      // back-to-back windows through a handshake with start
      b8.out_ready = 1'b0;
      b8.start = 1'b1;
      b8.win_len = 16'd2;
      tick();
      b8.start = 1'b0;
      b8.z = 1'b1;
      tick();
      b8.z = 1'b0;
      tick();
      chk("b2b_first_valid", 32'(b8.out_valid), 32'd1);
      chk("b2b_first_count", 32'(b8.out_count), 32'd1);
      b8.out_ready = 1'b1;
      b8.start = 1'b1;
      b8.win_len = 16'd3;
      b8.z = 1'b1;
      tick();
      chk("b2b_busy",  32'(b8.busy),      32'd1);
      chk("b2b_nvld",  32'(b8.out_valid), 32'd0);
      b8.start = 1'b0;
      b8.z = 1'b0;
      tick();
      tick();
      chk("b2b_nvld2", 32'(b8.out_valid), 32'd0);
      tick();
      chk("b2b_second_valid", 32'(b8.out_valid), 32'd1);
      chk("b2b_second_count", 32'(b8.out_count), 32'd0);
      tick();
      chk("b2b_idle", 32'(b8.busy), 32'd0);
      // saturation: 5 pulses in a 20-cycle window
      b8.start = 1'b1;
      b8.win_len = 16'd20;
      tick();
      b8.start = 1'b0;
      for (int e = 1; e <= 19; e++) begin
         b8.z = (e >= 2 && e <= 10 && (e % 2 == 0));
         tick();
      end
      b8.z = 1'b0;
      tick();
      chk("sat2_valid", 32'(b2.out_valid), 32'd1);
      chk("sat2_count", 32'(b2.out_count), 32'd3);
      chk("sat2_ovf",   32'(b2.out_ovf),   32'd1);
      chk("sat8_count", 32'(b8.out_count), 32'd5);
      chk("sat8_ovf",   32'(b8.out_ovf),   32'd0);
      tick();
      chk("sat_idle", 32'(b2.busy), 32'd0);
      // reset during COUNT
      b8.start = 1'b1;
      b8.win_len = 16'd8;
      tick();
      b8.start = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         b8.z = (e == 2);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  32'(b8.busy),      32'd0);
      chk("mid_rst_valid", 32'(b8.out_valid), 32'd0);
      chk("mid_rst_count", 32'(b8.out_count), 32'd0);
      chk("mid_rst_cnt2",  32'(b2.out_count), 32'd0);
      chk("mid_rst_ovf2",  32'(b2.out_ovf),   32'd0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("post_rst_valid", 32'(b8.out_valid), 32'd0);
         chk("post_rst_busy",  32'(b8.busy),      32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_match_counter.md
SEQ_MATCH_COUNTER -- requirements
Module: seq_match_counter

Interface
REQ-001 Parameter CNT_W, default 8, width of the match count and its saturation limit.
REQ-002 Parameter WIN_W, default 16, width of the window-length input.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 z  input  1  match flag from the upstream sequence detector, sampled every clk edge.
REQ-006 start  input  1  begin a counting window; honoured only in IDLE or on a REPORT handshake cycle.
REQ-007 win_len  input  WIN_W  window length in cycles, captured when start is accepted; 0 is treated as 1.
REQ-008 out_ready  input  1  consumer ready for the result.
REQ-009 out_valid  output  1  result available; high only in REPORT.
REQ-010 out_count  output  CNT_W  number of z rising edges counted in the window.
REQ-011 out_ovf  output  1  count saturated during the window.
REQ-012 busy  output  1  high in COUNT or REPORT.

Function
REQ-013 Rising edge defined as z=1 at the current edge and z=0 at the previous edge; previous-z register updates every cycle in every state.
REQ-014 FSM states IDLE, COUNT, REPORT; from reset the FSM is in IDLE.
REQ-015 IDLE: start=1 -> COUNT, remaining<=max(win_len,1), count<=0, ovf<=0; otherwise stay in IDLE.
REQ-016 COUNT: on each edge, if a rising edge is seen, count increments; remaining decrements.
REQ-017 COUNT with remaining=1 -> REPORT; that final cycle's rising edge is included in the count.
REQ-018 Window timing: start accepted at edge k, rising edges sampled at edges k+1..k+N are counted, and out_valid is high from edge k+N.
REQ-019 Saturation: count at 2^CNT_W-1 plus a rising edge -> count holds and ovf<=1; no wrap.
REQ-020 REPORT: out_valid=1; out_count and out_ovf stable until the handshake.
REQ-021 Handshake: out_valid & out_ready at an edge completes the transfer.
REQ-022 Handshake with start=1 -> COUNT, new window loaded as in REQ-015; handshake with start=0 -> IDLE.
REQ-023 start in COUNT, or in REPORT without out_ready, is ignored.
REQ-024 Rising edges in IDLE or REPORT are not counted; this includes the handshake cycle.
REQ-025 out_count and out_ovf hold their last value in IDLE and COUNT.
REQ-026 out_count and out_ovf update only on the edge entering REPORT.

Reset
REQ-027 rst_n low -> immediately: state=IDLE, count=0, ovf=0, remaining=0, previous-z=0, out_valid=0, out_count=0, out_ovf=0, busy=0.
REQ-028 Reset during COUNT or REPORT abandons the window; no result is emitted after release.
REQ-029 With z=1 at reset release, the first sampled z=1 counts as a rising edge if a window is open.

Structure
REQ-030 Shared package seq_pkg holds the state enum (IDLE/COUNT/REPORT) and default width constants CNT_W_DEF=8 and WIN_W_DEF=16.
REQ-031 One sub-module, rise_detect (registered previous-z, combinational rise output), instanced once.
REQ-032 All outputs are driven from registers or from state decode only; no combinational path from z to any output.

Verification
REQ-033 win_len=10; start at edge 0; z pulses (1 cycle) at edges 2 and 7; out_ready=1 -> out_valid at edge 10, out_count=2, out_ovf=0, IDLE at edge 11.
REQ-034 win_len=4; z pulse sampled exactly at edge 4 (last window cycle) -> counted, out_count=1; pulse at edge 5 -> not counted.
REQ-035 CNT_W=2, win_len=20, 5 separated z pulses -> out_count=3, out_ovf=1.
REQ-036 win_len=0 -> one-cycle window; out_valid at edge k+1.
REQ-037 REPORT with out_ready=0 for 5 cycles, z toggling and start=1 -> outputs stable, start ignored.
REQ-038 Handshake then immediate restart: out_ready=1 and start=1 on the same edge -> back-to-back windows, no IDLE cycle, second count starts at 0.
REQ-039 rst_n pulsed low mid-COUNT at edge 3 of 8 -> all outputs 0 asynchronously, no out_valid afterwards without a new start.
